// File: rtl/param_johnson_counter.sv
// param_johnson_counter
//   Parameterised Johnson (twisted-ring) counter with a sequence of 2*WIDTH codes.
//   It supports forward and reverse stepping and parallel load. It also provides a
//   registered phase index of the current code, a wrap pulse when the counter
//   returns to all-zeros, and an error pulse.
//   Optional build macro: JOHNSON_SELF_CORRECT_EN
//     When defined, illegal codes are detected on load and before every step.
//     The counter is then forced to all-zeros and err pulses.
//     When undefined, no checking logic exists and err is constant 0.
module param_johnson_counter #(
    parameter int WIDTH = 4,
    localparam int PW = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             err
);

    // Position of a legal code within the forward sequence.
    // Codes on the filling half (all-zeros, or MSB set) sit at their popcount.
    // Codes on the draining half sit at WIDTH plus their zero count,
    // i.e. 2*WIDTH minus their popcount.
    function automatic logic [PW-1:0] phase_of(input logic [WIDTH-1:0] code);
        logic [31:0] ones;
        ones = 32'd0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + {31'd0, code[i]};
        end
        if ((code == {WIDTH{1'b0}}) || code[WIDTH-1]) begin
            return PW'(ones);
        end else begin
            return PW'(32'(2 * WIDTH) - ones);
        end
    endfunction

`ifdef JOHNSON_SELF_CORRECT_EN
    // A Johnson code has at most one boundary between adjacent bits.
    function automatic logic code_legal(input logic [WIDTH-1:0] code);
        logic [31:0] edges;
        edges = 32'd0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            edges = edges + {31'd0, code[i] ^ code[i+1]};
        end
        return (edges <= 32'd1);
    endfunction
`endif

    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] nxt_out_s;
    logic [PW-1:0]    phase_r;
    logic [PW-1:0]    nxt_phase_s;
    logic             wrap_r;
    logic             nxt_wrap_s;
`ifdef JOHNSON_SELF_CORRECT_EN
    logic             err_r;
    logic             nxt_err_s;
`endif

    // One ring step from the current code in the direction sampled this cycle.
    always_comb begin
        step_s = out_r;
        if (dir) begin
            step_s = {out_r[WIDTH-2:0], ~out_r[WIDTH-1]};
        end else begin
            step_s = {~out_r[0], out_r[WIDTH-1:1]};
        end
    end

    // Next-state selection with priority load > step > hold.
    always_comb begin
        nxt_out_s   = out_r;
        nxt_phase_s = phase_r;
        nxt_wrap_s  = 1'b0;
`ifdef JOHNSON_SELF_CORRECT_EN
        nxt_err_s   = 1'b0;
        if (load) begin
            if (code_legal(load_val)) begin
                nxt_out_s   = load_val;
                nxt_phase_s = phase_of(load_val);
            end else begin
                nxt_out_s   = {WIDTH{1'b0}};
                nxt_phase_s = {PW{1'b0}};
                nxt_err_s   = 1'b1;
            end
        end else if (en) begin
            if (code_legal(out_r)) begin
                nxt_out_s   = step_s;
                nxt_phase_s = phase_of(step_s);
                nxt_wrap_s  = (out_r != {WIDTH{1'b0}}) && (step_s == {WIDTH{1'b0}});
            end else begin
                nxt_out_s   = {WIDTH{1'b0}};
                nxt_phase_s = {PW{1'b0}};
                nxt_err_s   = 1'b1;
            end
        end else begin
            nxt_out_s   = out_r;
            nxt_phase_s = phase_r;
        end
`else
        if (load) begin
            nxt_out_s   = load_val;
            nxt_phase_s = phase_of(load_val);
        end else if (en) begin
            nxt_out_s   = step_s;
            nxt_phase_s = phase_of(step_s);
            nxt_wrap_s  = (out_r != {WIDTH{1'b0}}) && (step_s == {WIDTH{1'b0}});
        end else begin
            nxt_out_s   = out_r;
            nxt_phase_s = phase_r;
        end
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_r   <= {WIDTH{1'b0}};
            phase_r <= {PW{1'b0}};
            wrap_r  <= 1'b0;
`ifdef JOHNSON_SELF_CORRECT_EN
            err_r   <= 1'b0;
`endif
        end else begin
            out_r   <= nxt_out_s;
            phase_r <= nxt_phase_s;
            wrap_r  <= nxt_wrap_s;
`ifdef JOHNSON_SELF_CORRECT_EN
            err_r   <= nxt_err_s;
`endif
        end
    end

    assign out   = out_r;
    assign phase = phase_r;
    assign wrap  = wrap_r;
`ifdef JOHNSON_SELF_CORRECT_EN
    assign err   = err_r;
`else
    assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_param_johnson_counter.sv
// Testbench for param_johnson_counter.
// Three instances (WIDTH 4, 5, 7) share the control inputs. A phase-index
// reference model tracks each instance. The model derives the expected code
// arithmetically from the phase index.
module tb_param_johnson_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, en, dir, load;
    logic [3:0] lv4, o4;
    logic [4:0] lv5, o5;
    logic [6:0] lv7, o7;
    logic [2:0] p4;
    logic [3:0] p5, p7;
    logic       w4, w5, w7, e4, e5, e7;

    param_johnson_counter #(.WIDTH(4)) u4 (.clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
        .load_val(lv4), .out(o4), .phase(p4), .wrap(w4), .err(e4));
    param_johnson_counter #(.WIDTH(5)) u5 (.clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
        .load_val(lv5), .out(o5), .phase(p5), .wrap(w5), .err(e5));
    param_johnson_counter #(.WIDTH(7)) u7 (.clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
        .load_val(lv7), .out(o7), .phase(p7), .wrap(w7), .err(e7));

    int errors = 0;
    int checks = 0;
    int wv[3] = '{4, 5, 7};
    int mp[3];
    bit mw[3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Code at index p of the forward sequence.
    // For p <= w, the top p bits are ones. Otherwise the low 2w-p bits are ones.
    function automatic logic [31:0] code_of(input int w, input int p);
        logic [31:0] ones;
        if (p <= w) begin
            ones = (32'd1 << p) - 32'd1;
            return ones << (w - p);
        end else begin
            return (32'd1 << (2 * w - p)) - 32'd1;
        end
    endfunction

    function automatic int index_of(input int w, input logic [31:0] code);
        for (int p = 0; p < 2 * w; p++) begin
            if (code_of(w, p) == code) return p;
        end
        return -1;
    endfunction

    function automatic logic [31:0] lv_of(input int k);
        case (k)
            0: return 32'(lv4);
            1: return 32'(lv5);
            default: return 32'(lv7);
        endcase
    endfunction

    function automatic logic [31:0] got_out(input int k);
        case (k)
            0: return 32'(o4);
            1: return 32'(o5);
            default: return 32'(o7);
        endcase
    endfunction

    function automatic logic [31:0] got_phase(input int k);
        case (k)
            0: return 32'(p4);
            1: return 32'(p5);
            default: return 32'(p7);
        endcase
    endfunction

    function automatic logic got_wrap(input int k);
        case (k)
            0: return w4;
            1: return w5;
            default: return w7;
        endcase
    endfunction

    function automatic logic got_err(input int k);
        case (k)
            0: return e4;
            1: return e5;
            default: return e7;
        endcase
    endfunction

    task automatic rand_loads();
        lv4 = 4'(code_of(4, $urandom_range(0, 7)));
        lv5 = 5'(code_of(5, $urandom_range(0, 9)));
        lv7 = 7'(code_of(7, $urandom_range(0, 13)));
    endtask

    // Advance the model with the driven inputs, clock once, and compare.
    // With skip0 set, instance 0 is left to the caller.
    task automatic step_cycle(input bit skip0);
        int old;
        for (int k = 0; k < 3; k++) begin
            if (!(skip0 && k == 0)) begin
                mw[k] = 1'b0;
                if (reset) begin
                    mp[k] = 0;
                end else if (load) begin
                    mp[k] = index_of(wv[k], lv_of(k));
                end else if (en) begin
                    old = mp[k];
                    mp[k] = dir ? (old + 2 * wv[k] - 1) % (2 * wv[k]) : (old + 1) % (2 * wv[k]);
                    mw[k] = (old != 0) && (mp[k] == 0);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (!(skip0 && k == 0)) begin
                chk($sformatf("out w%0d", wv[k]), got_out(k), code_of(wv[k], mp[k]));
                chk($sformatf("phase w%0d", wv[k]), got_phase(k), 32'(mp[k]));
                chk($sformatf("wrap w%0d", wv[k]), 32'(got_wrap(k)), 32'(mw[k]));
                chk($sformatf("err w%0d", wv[k]), 32'(got_err(k)), 32'd0);
            end
        end
    endtask

    task automatic set_ctl(input bit r, input bit e, input bit d, input bit l);
        reset = r; en = e; dir = d; load = l;
    endtask

    logic [3:0] seq4 [8] = '{4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0};
    int wraps;

    initial begin
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        lv4 = 4'h0; lv5 = 5'h0; lv7 = 7'h0;
        #2;
        step_cycle(1'b0);
        step_cycle(1'b0);
        chk("reset out", 32'(o4), 32'd0);

        // Full forward lap at WIDTH 4.
        set_ctl(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step_cycle(1'b0);
            chk("seq4 out", 32'(o4), 32'(seq4[i]));
            chk("seq4 wrap", 32'(w4), (i == 7) ? 32'd1 : 32'd0);
        end

        // Direction toggling from E.
        rand_loads(); lv4 = 4'hE;
        set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
        step_cycle(1'b0);
        chk("loadE phase", 32'(p4), 32'd3);
        set_ctl(1'b0, 1'b1, 1'b1, 1'b0); step_cycle(1'b0);
        chk("toggle1", {28'd0, o4}, 32'hC); chk("toggle1 ph", 32'(p4), 32'd2);
        set_ctl(1'b0, 1'b1, 1'b0, 1'b0); step_cycle(1'b0);
        chk("toggle2", {28'd0, o4}, 32'hE); chk("toggle2 ph", 32'(p4), 32'd3);
        set_ctl(1'b0, 1'b1, 1'b1, 1'b0); step_cycle(1'b0);
        chk("toggle3", {28'd0, o4}, 32'hC); chk("toggle3 ph", 32'(p4), 32'd2);

        // Load takes priority over en.
        rand_loads(); lv4 = 4'h3;
        set_ctl(1'b0, 1'b1, 1'b0, 1'b1); step_cycle(1'b0);
        chk("load3 out", 32'(o4), 32'd3); chk("load3 phase", 32'(p4), 32'd6);
        set_ctl(1'b0, 1'b1, 1'b0, 1'b0); step_cycle(1'b0);
        chk("after3 out", 32'(o4), 32'd1);
        step_cycle(1'b0);
        chk("after3 wrap", 32'(w4), 32'd1); chk("after3 zero", 32'(o4), 32'd0);

        // Illegal load at WIDTH 4.
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0); step_cycle(1'b0);
        rand_loads(); lv4 = 4'h5;
        set_ctl(1'b0, 1'b1, 1'b0, 1'b1); step_cycle(1'b1);
`ifdef JOHNSON_SELF_CORRECT_EN
        chk("illegal out", 32'(o4), 32'd0);
        chk("illegal phase", 32'(p4), 32'd0);
        chk("illegal err", 32'(e4), 32'd1);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0); step_cycle(1'b1);
        chk("illegal err clr", 32'(e4), 32'd0);
`else
        chk("unchecked out", 32'(o4), 32'd5);
        chk("unchecked err", 32'(e4), 32'd0);
`endif
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0); step_cycle(1'b0);

        // Reset mid-count at WIDTH 5 while en is held high.
        set_ctl(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step_cycle(1'b0);
        chk("w5 at 1C", 32'(o5), 32'h1C);
        set_ctl(1'b1, 1'b1, 1'b0, 1'b0); step_cycle(1'b0);
        chk("w5 rst out", 32'(o5), 32'd0); chk("w5 rst ph", 32'(p5), 32'd0);
        chk("w5 rst wrap", 32'(w5), 32'd0);
        set_ctl(1'b0, 1'b1, 1'b0, 1'b0); step_cycle(1'b0);
        chk("w5 resume1", 32'(o5), 32'h10);
        step_cycle(1'b0);
        chk("w5 resume2", 32'(o5), 32'h18);

        // WIDTH 7: one forward lap, then one reverse lap.
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0); step_cycle(1'b0);
        for (int d = 0; d < 2; d++) begin
            wraps = 0;
            set_ctl(1'b0, 1'b1, d[0], 1'b0);
            for (int i = 0; i < 14; i++) begin
                step_cycle(1'b0);
                if (w7) wraps++;
            end
            chk("w7 lap wraps", 32'(wraps), 32'd1);
            chk("w7 lap end", 32'(o7), 32'd0);
        end

        // Random traffic with legal load values.
        for (int i = 0; i < 400; i++) begin
            rand_loads();
            set_ctl(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 1) == 1, ($urandom_range(0, 7) == 0));
            step_cycle(1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_johnson_counter.md
PARAM_JOHNSON_COUNTER -- requirements
Module: param_johnson_counter

Interface
REQ-001 Parameter WIDTH, default 4, number of counter bits; legal range 2..32; the sequence length is 2*WIDTH states.
REQ-002 Local parameter PW = clog2(2*WIDTH) sets the phase index width.
REQ-003 clk  input  1  the single clock; all logic updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 en  input  1  advances the counter by one state when high.
REQ-006 dir  input  1  selects direction: 0 = forward, 1 = reverse.
REQ-007 load  input  1  loads load_val in place of stepping.
REQ-008 load_val  input  WIDTH  value to load.
REQ-009 out  output  WIDTH  registered Johnson code.
REQ-010 phase  output  PW  registered index (0..2*WIDTH-1) of out within the forward sequence.
REQ-011 wrap  output  1  registered one-cycle pulse; the counter has returned to all-zeros.
REQ-012 err  output  1  registered one-cycle pulse; an illegal code was detected (see Configuration).

Function
REQ-013 Control priority SHALL be reset > load > en > hold; when en=0 and load=0, out and phase hold their values.
REQ-014 Forward step SHALL set out[WIDTH-1] <= ~out[0] and out[i] <= out[i+1] for i = 0..WIDTH-2, giving 0000 -> 1000 -> 1100 -> 1110 -> 1111 -> 0111 -> 0011 -> 0001 -> 0000 for WIDTH=4.
REQ-015 Reverse step SHALL set out[0] <= ~out[WIDTH-1] and out[i] <= out[i-1] for i = 1..WIDTH-1, giving the exact inverse of the forward sequence.
REQ-016 A code is legal if it has at most one bit-to-bit change across adjacent positions out[i] and out[i+1]; a WIDTH-bit vector therefore has exactly 2*WIDTH legal codes.
REQ-017 phase decode for a legal code: all-zeros or out[WIDTH-1]=1 gives phase = popcount(out); otherwise phase = WIDTH + number of zero bits. phase SHALL update in the same cycle as out, with zero extra latency.
REQ-018 Forward stepping SHALL increment phase modulo 2*WIDTH; reverse stepping SHALL decrement it modulo 2*WIDTH.
REQ-019 wrap SHALL be 1 in the cycle after a step in either direction that changes out from a nonzero value to all-zeros; it is 0 otherwise, including after a load of zero.
REQ-020 dir SHALL be allowed to change on any cycle; each step uses the dir value sampled on that edge, with no dead cycle.
REQ-021 A load asserted together with en SHALL perform the load only; no step occurs in that cycle.
REQ-022 A legal load SHALL set out = load_val and phase = decode(load_val) on the next edge; wrap=0 and err=0.

Reset
REQ-023 While reset=1 at a clk edge: out = 0, phase = 0, wrap = 0, err = 0; load and en are ignored.
REQ-024 Reset SHALL override any operation in progress; the first step after reset is released is 0 -> forward state 1 (or 2*WIDTH-1 when dir=1).

Configuration
REQ-025 Macro JOHNSON_SELF_CORRECT_EN SHALL control legality checking.
REQ-026 With JOHNSON_SELF_CORRECT_EN defined: a load of an illegal load_val SHALL set out = 0 and phase = 0 and pulse err for one cycle; if out is ever illegal at an enabled step, the step SHALL instead set out = 0 and phase = 0 and pulse err.
REQ-027 With JOHNSON_SELF_CORRECT_EN undefined: load_val is loaded unchecked; stepping applies REQ-014/015 unchanged; err is tied to 0; phase for an illegal out is don't-care; no checking logic is synthesised.

Verification
REQ-028 WIDTH=4: reset, then en=1, dir=0 for 9 cycles -> out sequence 0,8,C,E,F,7,3,1,0; phase 0..7 then 0; wrap=1 only on the final cycle.
REQ-029 WIDTH=4: from out=E (phase 3), en=1 with dir toggling 1,0,1 -> out C, E, C; phase 2, 3, 2.
REQ-030 WIDTH=4: load=1, en=1, load_val=3 -> out=3, phase=6, no step; then en=1, dir=0 for 2 cycles -> 1, then 0 with wrap=1.
REQ-031 WIDTH=4 with JOHNSON_SELF_CORRECT_EN: load_val=5 (illegal) -> out=0, phase=0, err=1 for one cycle. Without the macro: out=5, err=0.
REQ-032 WIDTH=5: en held high while reset is asserted mid-count at out=1C -> next cycle out=0, phase=0, wrap=0; counting resumes 10, 18.
REQ-033 WIDTH=7: 14 forward steps, then 14 reverse steps -> each run returns to 0 with exactly one wrap pulse, and phase matches the decode on every cycle.
